// File: rtl/rll_key_pkg.sv
// Shared types and constants for the rll32 unlock-key loader.
// RLL_KEY_PARITY_EN (when defined) adds an even-parity bit to every load.
package rll_key_pkg;

    localparam int RLL_KEY_W           = 32;
    localparam int RLL_KEY_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        LOCKED,
        ERROR
    } key_state_e;

    function automatic logic is_loading(key_state_e s);
        return (s == SHIFT) || (s == PARITY);
    endfunction

endpackage

// File: rtl/rll_key_timeout_ctr.sv
// Saturating idle counter: counts while inc is high, clears on clr,
// flags expired once it sits at LIMIT-1. Never wraps.
module rll_key_timeout_ctr
    import rll_key_pkg::*;
#(
    parameter int LIMIT = RLL_KEY_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] MAX = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == MAX);

endmodule

// File: rtl/rll_key_loader.sv
// Serial-to-parallel unlock-key loader for the rll32 locked netlists.
// Define RLL_KEY_PARITY_EN to require a trailing even-parity bit per key.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W       = RLL_KEY_W,
    parameter int TIMEOUT_CYC = RLL_KEY_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_bit_in,
    input  logic             key_bit_valid,
    output logic             key_bit_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W - 1);

    key_state_e       state, state_d;
    logic [KEY_W-1:0] shreg, shreg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             in_load, accept;
    logic             tmr_clr, tmr_expired;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // A restart request always wins; otherwise only a handshake or timeout moves the FSM.
    always_comb begin
        state_d = state;
        if (load_start) begin
            state_d = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    if (accept) begin
                        if (cnt == LAST) begin
`ifdef RLL_KEY_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = LOCKED;
`endif
                        end
                    end else if (tmr_expired) begin
                        state_d = ERROR;
                    end
                end
`ifdef RLL_KEY_PARITY_EN
                PARITY: begin
                    if (accept)           state_d = ((^shreg) ^ key_bit_in) ? ERROR : LOCKED;
                    else if (tmr_expired) state_d = ERROR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        in_load       = is_loading(state);
        busy          = in_load;
        key_bit_ready = in_load && !load_start;
        accept        = key_bit_ready && key_bit_valid;
    end

    always_comb begin
        shreg_d = shreg;
        cnt_d   = cnt;
        if (load_start) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (accept && (state == SHIFT)) begin
            shreg_d[cnt[IDX_W-1:0]] = key_bit_in;
            cnt_d                   = cnt + 1'b1;
        end
    end

    assign tmr_clr = !in_load || load_start || accept;

    rll_key_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (in_load),
        .expired (tmr_expired)
    );

    // Outputs follow the next state so the key shows the cycle after the final accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            key_out   <= (state_d == LOCKED) ? shreg_d : '0;
            key_valid <= (state_d == LOCKED);
            err       <= (state_d == ERROR);
        end
    end

endmodule
